axi_lite_mem_responder: RTL and testbench

AXI4-Lite slave memory model that terminates the traffic controller's M_AXI master port inside the example block design. It accepts the write and read transactions the traffic generator issues and returns BRESP/RRESP. These responses drive the generator's M_AXI_ERROR/M_AXI_TXN_DONE outcome. It keeps saturating transaction and error counters for bench visibility.

---
 rtl/axi_lite_mem_responder.sv | 267 ++++++++++++++++++++++++++
 tb/tb_axi_lite_mem_responder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_mem_responder.sv
// -----------------------------------------------------------------------------
// axi_lite_mem_responder
//
// AXI4-Lite slave memory model. Terminates a traffic generator's master port,
// answers every write with BRESP and every read with RDATA/RRESP, and keeps
// saturating counters of completed writes, reads and SLVERR responses.
//
// Storage is MEM_DEPTH 32-bit words starting at byte address 0. Any address at
// or above MEM_DEPTH*4 is answered with SLVERR; such writes are dropped and
// such reads return zero. addr[1:0] is ignored.
//
// Optional build macro:
//   AXI_RESP_STALL_EN - a 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded
//                       with STALL_SEED on reset, forces AWREADY, WREADY and
//                       ARREADY low on every cycle where LFSR[0] is 1.
//                       Undefined by default: no LFSR is built.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN     clock; synchronous active-low reset
//   S_AXI_AW* / S_AXI_W*          write address / write data channels
//   S_AXI_B*                      write response channel
//   S_AXI_AR* / S_AXI_R*          read address / read data channels
//   WR_COUNT, RD_COUNT            completed B / R handshakes (saturating)
//   ERR_COUNT                     SLVERR responses handed over (saturating)
// -----------------------------------------------------------------------------
module axi_lite_mem_responder #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 32,
  parameter int          MEM_DEPTH          = 64,
  parameter logic [15:0] STALL_SEED         = 16'hACE1
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [15:0]                     WR_COUNT,
  output logic [15:0]                     RD_COUNT,
  output logic [15:0]                     ERR_COUNT
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] MEM_BYTES =
    C_S_AXI_ADDR_WIDTH'(MEM_DEPTH * 4);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Zero at configuration time; reset never touches the array.
  logic [C_S_AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH] = '{default: '0};

  logic                          ready_en_q;
  logic                          aw_held_q,  aw_held_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q,  aw_addr_d;
  logic                          w_held_q,   w_held_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q,   w_data_d;
  logic [STRB_W-1:0]             w_strb_q,   w_strb_d;
  logic                          bvalid_q,   bvalid_d;
  logic [1:0]                    bresp_q,    bresp_d;
  logic                          rvalid_q,   rvalid_d;
  logic [1:0]                    rresp_q,    rresp_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q,    rdata_d;
  logic [15:0]                   wr_cnt_q,   wr_cnt_d;
  logic [15:0]                   rd_cnt_q,   rd_cnt_d;
  logic [15:0]                   err_cnt_q,  err_cnt_d;

  logic                          stall;
  logic                          awready, wready, arready;
  logic                          aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                          commit;
  logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]             wr_strb;
  logic                          wr_in_range, rd_in_range;
  logic [IDX_W-1:0]              wr_idx, rd_idx;
  logic [1:0]                    err_inc;

  // ---------------------------------------------------------------------------
  // Optional backpressure generator
  // ---------------------------------------------------------------------------
`ifdef AXI_RESP_STALL_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) lfsr_q <= STALL_SEED;
    else                lfsr_q <= {lfsr_q[14:0], lfsr_fb};
  end

  assign stall = lfsr_q[0];
`else
  logic [15:0] unused_seed;
  assign unused_seed = STALL_SEED;
  assign stall       = 1'b0;
`endif

  logic unused_prot;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  // ---------------------------------------------------------------------------
  // Handshakes and decode
  // ---------------------------------------------------------------------------
  // READY is held low during reset and for the release cycle itself; it comes
  // up from the first edge that sees S_AXI_ARESETN high.
  assign awready = S_AXI_ARESETN && ready_en_q && !stall && !aw_held_q && !bvalid_q;
  assign wready  = S_AXI_ARESETN && ready_en_q && !stall && !w_held_q  && !bvalid_q;
  assign arready = S_AXI_ARESETN && ready_en_q && !stall && !rvalid_q;

  assign aw_hs = S_AXI_AWVALID && awready;
  assign w_hs  = S_AXI_WVALID  && wready;
  assign b_hs  = bvalid_q && S_AXI_BREADY;
  assign ar_hs = S_AXI_ARVALID && arready;
  assign r_hs  = rvalid_q && S_AXI_RREADY;

  // Holding registers bypass: a channel accepted this cycle counts as held, so
  // AW and W arriving together commit in their handshake cycle.
  assign wr_addr = aw_held_q ? aw_addr_q : S_AXI_AWADDR;
  assign wr_data = w_held_q  ? w_data_q  : S_AXI_WDATA;
  assign wr_strb = w_held_q  ? w_strb_q  : S_AXI_WSTRB;
  assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);

  assign wr_in_range = (wr_addr < MEM_BYTES);
  assign rd_in_range = (S_AXI_ARADDR < MEM_BYTES);
  assign wr_idx      = wr_addr[IDX_W+1:2];
  assign rd_idx      = S_AXI_ARADDR[IDX_W+1:2];

  assign err_inc = {1'b0, b_hs && (bresp_q == RESP_SLVERR)}
                 + {1'b0, r_hs && (rresp_q == RESP_SLVERR)};

  function automatic logic [15:0] sat_add(input logic [15:0] cnt,
                                          input logic [1:0]  inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every _d gets its hold value first so no path through this block can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = S_AXI_AWADDR;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end

    if (b_hs) bvalid_d = 1'b0;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end

    if (r_hs) rvalid_d = 1'b0;
    if (ar_hs) begin
      // mem_q still holds pre-commit contents this cycle: read-before-write.
      rvalid_d = 1'b1;
      rresp_d  = rd_in_range ? RESP_OKAY : RESP_SLVERR;
      rdata_d  = rd_in_range ? mem_q[rd_idx] : '0;
    end

    wr_cnt_d  = sat_add(wr_cnt_q,  {1'b0, b_hs});
    rd_cnt_d  = sat_add(rd_cnt_q,  {1'b0, r_hs});
    err_cnt_d = sat_add(err_cnt_q, err_inc);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      err_cnt_q  <= '0;
    end else begin
      ready_en_q <= 1'b1;
      aw_held_q  <= aw_held_d;
      aw_addr_q  <= aw_addr_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // NOTE: the storage array has no reset branch; its contents must survive a
  // bus reset, and leaving it out keeps it mappable onto block RAM.
  always_ff @(posedge S_AXI_ACLK) begin
    if (commit && wr_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign WR_COUNT      = wr_cnt_q;
  assign RD_COUNT      = rd_cnt_q;
  assign ERR_COUNT     = err_cnt_q;

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_mem_responder
//
// Directed bench for axi_lite_mem_responder (default build, MEM_DEPTH=64).
// Inputs are driven and outputs sampled on the falling clock edge; the DUT
// acts on the rising edge in between.
// -----------------------------------------------------------------------------
module tb_axi_lite_mem_responder;

  logic        S_AXI_ACLK = 1'b0;
  logic        S_AXI_ARESETN;
  logic [31:0] S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [31:0] S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [15:0] WR_COUNT;
  logic [15:0] RD_COUNT;
  logic [15:0] ERR_COUNT;

  int total = 0;
  int bad   = 0;

  axi_lite_mem_responder dut (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .S_AXI_ARESETN (S_AXI_ARESETN),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .WR_COUNT      (WR_COUNT),
    .RD_COUNT      (RD_COUNT),
    .ERR_COUNT     (ERR_COUNT)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge S_AXI_ACLK);
  endtask

  // AW and W presented together, BREADY held high; returns BRESP.
  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done = 0;
    bit w_done  = 0;
    bit got_b   = 0;
    S_AXI_AWADDR  = addr;
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_BREADY  = 1'b1;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
      if (S_AXI_WVALID  && S_AXI_WREADY)  w_done  = 1;
      tick();
      if (aw_done) S_AXI_AWVALID = 1'b0;
      if (w_done)  S_AXI_WVALID  = 1'b0;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check("wr_addr_data_accepted", {31'd0, aw_done && w_done}, 32'd1);
    resp = 2'bxx;
    for (int n = 0; n < 20; n++) begin
      if (S_AXI_BVALID) begin
        got_b = 1;
        resp  = S_AXI_BRESP;
        break;
      end
      tick();
    end
    check("wr_bvalid_seen", {31'd0, got_b}, 32'd1);
    tick();
    S_AXI_BREADY = 1'b0;
  endtask

  // AR presented, RREADY held high; returns RDATA/RRESP.
  task automatic read_txn(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    bit ar_done = 0;
    bit got_r   = 0;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    S_AXI_RREADY  = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (S_AXI_ARREADY) begin
        ar_done = 1;
        break;
      end
      tick();
    end
    tick();
    S_AXI_ARVALID = 1'b0;
    check("rd_addr_accepted", {31'd0, ar_done}, 32'd1);
    data = 'x;
    resp = 2'bxx;
    for (int n = 0; n < 20; n++) begin
      if (S_AXI_RVALID) begin
        got_r = 1;
        data  = S_AXI_RDATA;
        resp  = S_AXI_RRESP;
        break;
      end
      tick();
    end
    check("rd_rvalid_seen", {31'd0, got_r}, 32'd1);
    tick();
    S_AXI_RREADY = 1'b0;
  endtask

  initial begin : stim
    logic [1:0]  resp;
    logic [31:0] data;

    S_AXI_ARESETN = 1'b0;
    S_AXI_AWADDR  = '0;
    S_AXI_AWPROT  = '0;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA   = '0;
    S_AXI_WSTRB   = '0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b0;
    S_AXI_ARADDR  = '0;
    S_AXI_ARPROT  = '0;
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b0;

    // ---- Reset state -------------------------------------------------------
    tick(); tick(); tick();
    check("rst_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
    check("rst_arready", {31'd0, S_AXI_ARREADY}, 32'd0);
    check("rst_bvalid",  {31'd0, S_AXI_BVALID},  32'd0);
    check("rst_rvalid",  {31'd0, S_AXI_RVALID},  32'd0);
    check("rst_rdata",   S_AXI_RDATA,            32'd0);
    check("rst_counts",  {WR_COUNT, RD_COUNT | ERR_COUNT}, 32'd0);
    S_AXI_ARESETN = 1'b1;
    #1;
    check("release_wready_low", {31'd0, S_AXI_WREADY}, 32'd0);
    tick();
    check("release_awready", {31'd0, S_AXI_AWREADY}, 32'd1);

    // ---- 1: AW + W together to 0x10 ---------------------------------------
    S_AXI_AWADDR  = 32'h10;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA   = 32'hDEADBEEF;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_WVALID  = 1'b1;
    check("t1_ready_both", {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 32'd3);
    tick();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check("t1_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
    check("t1_bresp",  {30'd0, S_AXI_BRESP},  32'd0);
    check("t1_awready_blocked", {31'd0, S_AXI_AWREADY}, 32'd0);
    check("t1_wr_count_before_b", {16'd0, WR_COUNT}, 32'd0);
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    check("t1_bvalid_dropped", {31'd0, S_AXI_BVALID}, 32'd0);
    check("t1_wr_count", {16'd0, WR_COUNT}, 32'd1);

    // ---- 2: read 0x10, one-cycle latency ----------------------------------
    S_AXI_ARADDR  = 32'h10;
    S_AXI_ARVALID = 1'b1;
    check("t2_arready", {31'd0, S_AXI_ARREADY}, 32'd1);
    tick();
    S_AXI_ARVALID = 1'b0;
    check("t2_rvalid", {31'd0, S_AXI_RVALID}, 32'd1);
    check("t2_rdata",  S_AXI_RDATA, 32'hDEADBEEF);
    check("t2_rresp",  {30'd0, S_AXI_RRESP}, 32'd0);
    check("t2_arready_blocked", {31'd0, S_AXI_ARREADY}, 32'd0);
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
    check("t2_rvalid_dropped", {31'd0, S_AXI_RVALID}, 32'd0);
    check("t2_rd_count", {16'd0, RD_COUNT}, 32'd1);

    // ---- 3: W three cycles ahead of AW, partial strobes -------------------
    S_AXI_WDATA  = 32'h11223344;
    S_AXI_WSTRB  = 4'b0101;
    S_AXI_WVALID = 1'b1;
    S_AXI_BREADY = 1'b1;
    check("t3_wready", {31'd0, S_AXI_WREADY}, 32'd1);
    tick();
    S_AXI_WVALID = 1'b0;
    check("t3_w_held_wready_low", {31'd0, S_AXI_WREADY}, 32'd0);
    check("t3_no_b_1", {31'd0, S_AXI_BVALID}, 32'd0);
    tick();
    check("t3_no_b_2", {31'd0, S_AXI_BVALID}, 32'd0);
    tick();
    check("t3_no_b_3", {31'd0, S_AXI_BVALID}, 32'd0);
    S_AXI_AWADDR  = 32'h10;
    S_AXI_AWVALID = 1'b1;
    check("t3_awready", {31'd0, S_AXI_AWREADY}, 32'd1);
    tick();
    S_AXI_AWVALID = 1'b0;
    check("t3_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
    check("t3_bresp",  {30'd0, S_AXI_BRESP},  32'd0);
    tick();
    S_AXI_BREADY = 1'b0;
    check("t3_wr_count", {16'd0, WR_COUNT}, 32'd2);
    read_txn(32'h10, data, resp);
    check("t3_readback", data, 32'hDE22BE44);
    check("t3_rd_count", {16'd0, RD_COUNT}, 32'd2);

    // ---- 4: out of range at 0x100 (aliases word 0 if decoded wrongly) ----
    write_txn(32'h100, 32'hCAFEF00D, 4'hF, resp);
    check("t4_bresp_slverr", {30'd0, resp}, 32'd2);
    read_txn(32'h100, data, resp);
    check("t4_rresp_slverr", {30'd0, resp}, 32'd2);
    check("t4_rdata_zero",   data, 32'd0);
    check("t4_err_count", {16'd0, ERR_COUNT}, 32'd2);
    read_txn(32'h0, data, resp);
    check("t4_word0_unchanged", data, 32'd0);
    check("t4_word0_rresp", {30'd0, resp}, 32'd0);

    // ---- Last in-range word 0xFC, addr[1:0] ignored on read ---------------
    write_txn(32'hFC, 32'h5A5A1234, 4'hF, resp);
    check("top_word_bresp", {30'd0, resp}, 32'd0);
    read_txn(32'hFF, data, resp);
    check("top_word_rdata", data, 32'h5A5A1234);
    check("top_word_rresp", {30'd0, resp}, 32'd0);

    // ---- 5: B backpressure for 5 cycles -----------------------------------
    S_AXI_AWADDR  = 32'h20;
    S_AXI_WDATA   = 32'h0BADCAFE;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    for (int n = 0; n < 5; n++) begin
      check("t5_hold_bvalid", {31'd0, S_AXI_BVALID}, 32'd1);
      check("t5_hold_bresp",  {30'd0, S_AXI_BRESP},  32'd0);
      check("t5_hold_readys", {30'd0, S_AXI_AWREADY, S_AXI_WREADY}, 32'd0);
      tick();
    end
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    check("t5_bvalid_dropped", {31'd0, S_AXI_BVALID}, 32'd0);
    check("t5_awready_back", {31'd0, S_AXI_AWREADY}, 32'd1);
    check("t5_counts", {WR_COUNT, RD_COUNT}, {16'd5, 16'd5});
    check("t5_err_count", {16'd0, ERR_COUNT}, 32'd2);

    // ---- 6: reset with RVALID pending -------------------------------------
    S_AXI_ARADDR  = 32'h20;
    S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    check("t6_rvalid_pending", {31'd0, S_AXI_RVALID}, 32'd1);
    S_AXI_ARESETN = 1'b0;
    tick();
    check("t6_rvalid_cleared", {31'd0, S_AXI_RVALID}, 32'd0);
    check("t6_counts_cleared", {WR_COUNT, RD_COUNT}, 32'd0);
    check("t6_err_cleared", {16'd0, ERR_COUNT}, 32'd0);
    check("t6_arready_in_reset", {31'd0, S_AXI_ARREADY}, 32'd0);
    S_AXI_ARESETN = 1'b1;
    tick();
    read_txn(32'h10, data, resp);
    check("t6_mem_kept_10", data, 32'hDE22BE44);
    read_txn(32'h20, data, resp);
    check("t6_mem_kept_20", data, 32'h0BADCAFE);
    check("t6_rd_count", {16'd0, RD_COUNT}, 32'd2);

    // ---- Read and write commit to the same word in one cycle --------------
    S_AXI_AWADDR  = 32'h10;
    S_AXI_WDATA   = 32'h01020304;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_ARADDR  = 32'h10;
    S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    check("rbw_both_valid", {30'd0, S_AXI_BVALID, S_AXI_RVALID}, 32'd3);
    check("rbw_old_data", S_AXI_RDATA, 32'hDE22BE44);
    S_AXI_BREADY = 1'b1;
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    S_AXI_RREADY = 1'b0;
    check("rbw_counts", {WR_COUNT, RD_COUNT}, {16'd1, 16'd3});
    read_txn(32'h10, data, resp);
    check("rbw_new_data", data, 32'h01020304);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
